received_pair_deframer: RTL

Recovers framed bytes from the two line signals that `SplitRadio` produces, `Received1236` and `Received4578`. It sits directly downstream of `SplitRadio` in `LinkPowerNoPLC` and runs on the 100 MHz clock that `OscilateFromXtalDDR` makes. Each symbol carries one dibit: pair 1236 supplies bit 0 and pair 4578 supplies bit 1. The block oversamples both lines, hunts for a sync byte, assembles bytes and delivers them over a valid/ready handshake. It also flags frame end and overrun.

---
 rtl/received_pair_deframer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/received_pair_deframer.sv
// received_pair_deframer
//
// Recovers framed bytes from the two SplitRadio line signals. Each line
// symbol carries one dibit: Received1236 is bit 0 and Received4578 is bit 1.
// Both lines are synchronized and oversampled. A phase counter, re-aligned
// on every Received1236 transition, picks the mid-symbol sample point.
// In HUNT the block slides a dibit window until it equals SYNC_BYTE. In DATA
// it assembles bytes, LSB dibit first, and delivers them over valid/ready.
// A run of IDLE_SYMBOLS consecutive 00 dibits ends the frame.
//
// Handshake: RxByte is held stable while RxValid is high. A byte transfers in
// any cycle where RxValid & RxReady. If a new byte completes while the held
// byte has not been taken, the new byte is dropped and Overrun sticks at 1.
//
// Ports:
//   Clock100Mhz   in   the only clock, rising edge
//   Reset         in   synchronous, active-high
//   Received1236  in   async line, dibit bit 0
//   Received4578  in   async line, dibit bit 1
//   RxByte        out  [7:0] received byte
//   RxValid       out  RxByte holds an undelivered byte
//   RxReady       in   consumer accepts RxByte
//   FrameActive   out  high while in DATA
//   FrameEnd      out  one-cycle pulse when idle ends a frame
//   Overrun       out  sticky, a byte was dropped
//   o_dbg_state   out  FSM state (0 = HUNT, 1 = DATA)
module received_pair_deframer #(
    parameter int          OVERSAMPLE   = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hD5,
    parameter int          IDLE_SYMBOLS = 8
) (
    input  logic       Clock100Mhz,
    input  logic       Reset,
    input  logic       Received1236,
    input  logic       Received4578,
    output logic [7:0] RxByte,
    output logic       RxValid,
    input  logic       RxReady,
    output logic       FrameActive,
    output logic       FrameEnd,
    output logic       Overrun,
    output logic       o_dbg_state
);

    localparam int              CW         = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0]   CNT_MID    = CW'(OVERSAMPLE / 2);
    localparam int              IW         = $clog2(IDLE_SYMBOLS + 1);
    localparam logic [IW-1:0]   IDLE_LIMIT = IW'(IDLE_SYMBOLS);

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    // Synchronizers and edge detect
    logic          r_meta_1236;
    logic          r_s1236;
    logic          r_meta_4578;
    logic          r_s4578;
    logic          r_prev_1236;

    // Symbol timing
    logic [CW-1:0] r_cnt;
    logic          w_edge;
    logic [CW-1:0] w_phase;
    logic          w_strobe;
    logic [1:0]    w_dibit;

    // FSM and datapath
    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_window;
    logic [7:0]    w_window_next;
    logic [7:0]    w_window_shift;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic [1:0]    r_idx;
    logic [1:0]    w_idx_next;
    logic [IW-1:0] r_idle;
    logic [IW-1:0] w_idle_next;
    logic          w_complete;
    logic [7:0]    w_byte;
    logic          w_frame_end;

    // Output registers
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_frame_end;
    logic          r_overrun;

    // A transition on the 1236 line marks a symbol boundary; treat the
    // counter as 0 in that very cycle so the resync beats the wrap.
    assign w_edge   = r_s1236 ^ r_prev_1236;
    assign w_phase  = w_edge ? '0 : r_cnt;
    assign w_strobe = (w_phase == CNT_MID);
    assign w_dibit  = {r_s4578, r_s1236};

    assign w_window_shift = {w_dibit, r_window[7:2]};
    assign w_byte         = {w_dibit, r_shift[7:2]};

    always_ff @(posedge Clock100Mhz) begin
        if (Reset) begin
            r_meta_1236 <= 1'b0;
            r_s1236     <= 1'b0;
            r_meta_4578 <= 1'b0;
            r_s4578     <= 1'b0;
            r_prev_1236 <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_meta_1236 <= Received1236;
            r_s1236     <= r_meta_1236;
            r_meta_4578 <= Received4578;
            r_s4578     <= r_meta_4578;
            r_prev_1236 <= r_s1236;
            r_cnt       <= (w_phase == CNT_LAST) ? '0 : w_phase + CW'(1);
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_window_next = r_window;
        w_shift_next  = r_shift;
        w_idx_next    = r_idx;
        w_idle_next   = r_idle;
        w_complete    = 1'b0;
        w_frame_end   = 1'b0;

        case (r_state)
            HUNT: begin
                if (w_strobe) begin
                    w_window_next = w_window_shift;
                    if (w_window_shift == SYNC_BYTE) begin
                        w_state_next = DATA;
                        w_idx_next   = 2'd0;
                        w_idle_next  = '0;
                        w_shift_next = 8'h00;
                    end
                end
            end
            DATA: begin
                if (w_strobe) begin
                    w_shift_next = w_byte;
                    w_idx_next   = r_idx + 2'd1;
                    w_complete   = (r_idx == 2'd3);
                    w_idle_next  = (w_dibit == 2'b00) ? r_idle + IW'(1) : '0;
                    // A byte completing on the same strobe still goes out;
                    // only the partial byte is discarded.
                    if (w_idle_next == IDLE_LIMIT) begin
                        w_state_next  = HUNT;
                        w_frame_end   = 1'b1;
                        w_window_next = 8'h00;
                        w_idx_next    = 2'd0;
                        w_idle_next   = '0;
                    end
                end
            end
            default: begin
                w_state_next = HUNT;
            end
        endcase
    end

    always_ff @(posedge Clock100Mhz) begin
        if (Reset) begin
            r_state     <= HUNT;
            r_window    <= 8'h00;
            r_shift     <= 8'h00;
            r_idx       <= 2'd0;
            r_idle      <= '0;
            r_byte      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_end <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_window    <= w_window_next;
            r_shift     <= w_shift_next;
            r_idx       <= w_idx_next;
            r_idle      <= w_idle_next;
            r_frame_end <= w_frame_end;
            if (w_complete) begin
                if (!r_valid || RxReady) begin
                    r_byte  <= w_byte;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && RxReady) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign RxByte      = r_byte;
    assign RxValid     = r_valid;
    assign FrameActive = (r_state == DATA);
    assign FrameEnd    = r_frame_end;
    assign Overrun     = r_overrun;
    assign o_dbg_state = r_state;

endmodule
